// File: rtl/kernel_window_sequencer_pkg.sv
// Shared types and constants for the 3x3 kernel window sequencer.
package kernel_window_sequencer_pkg;

   // Job phases; IDLE is encoded as zero so a cleared state reads as idle.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      EXEC  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } kws_state_t;

   // ALU function-type encodings presented on funtype.
   localparam logic [1:0] FUNTYPE_KERNEL = 2'b11;
   localparam logic [1:0] FUNTYPE_ARITH  = 2'b00;

   // Index of the bottom row of a 3-row window.
   localparam logic [1:0] LAST_ROW_IDX = 2'd2;

endpackage

// File: rtl/kernel_window_sequencer_addr_gen.sv
// Window position counters (x, y, row) and the source/destination address
// arithmetic for the kernel window sequencer. All address math wraps modulo
// 2^AW; the multiplies use the image width latched at job start.
module window_addr_gen
   import kernel_window_sequencer_pkg::*;
#(
   parameter int AW = 16,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          row_adv,
   input  logic          win_adv,
   input  logic [DW-1:0] img_w,
   input  logic [DW-1:0] img_h,
   input  logic [AW-1:0] src_base,
   input  logic [AW-1:0] dst_base,
   output logic [AW-1:0] src_addr,
   output logic [AW-1:0] dst_addr,
   output logic [1:0]    row,
   output logic          last_row,
   output logic          last_win
);

   localparam logic [DW-1:0] DW_TWO   = DW'(2);
   localparam logic [DW-1:0] DW_THREE = DW'(3);

   logic [DW-1:0] x;
   logic [DW-1:0] y;
   logic [1:0]    r;
   logic          x_last;
   logic          y_last;
   logic [AW-1:0] row_idx;
   logic [AW-1:0] w_aw;
   logic [AW-1:0] span_aw;

   // Rightmost / bottom-most window origin for the latched image size.
   assign x_last = (x == img_w - DW_THREE);
   assign y_last = (y == img_h - DW_THREE);

   assign row      = r;
   assign last_row = (r == LAST_ROW_IDX);
   assign last_win = x_last && y_last;

   // Source row (y+r), pixel x; destination image is (img_w-2) wide.
   assign row_idx  = AW'(y) + AW'(r);
   assign w_aw     = AW'(img_w);
   assign span_aw  = AW'(img_w - DW_TWO);
   assign src_addr = src_base + row_idx * w_aw + AW'(x);
   assign dst_addr = dst_base + AW'(y) * span_aw + AW'(x);

   // Row steps on each fetched row; window steps raster-order after a write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x <= '0;
         y <= '0;
         r <= '0;
      end else if (clear) begin
         x <= '0;
         y <= '0;
         r <= '0;
      end else if (row_adv) begin
         r <= r + 2'd1;
      end else if (win_adv) begin
         r <= '0;
         if (x_last) begin
            x <= '0;
            y <= y + DW'(1);
         end else begin
            x <= x + DW'(1);
         end
      end
   end

endmodule

// File: rtl/kernel_window_sequencer.sv
// Walks an image as a 3x3 sliding window: for each window it reads three
// packed rows into the cache, runs the ALU kernel path for one cycle and
// writes the single result pixel to the destination image.
//
// Handshakes: mem_req/wr_req rise when a transfer is wanted and stay high,
// with address/data stable, until the matching ack is seen high on a rising
// edge; an ack while its req is low is ignored. mem_req may remain high
// across consecutive row reads, the address moving only after each ack.
module kernel_window_sequencer
   import kernel_window_sequencer_pkg::*;
#(
   parameter int bus = 4,
   parameter int AW  = 16,
   parameter int DW  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       ksel_in,
   input  logic [DW-1:0]    img_w,
   input  logic [DW-1:0]    img_h,
   input  logic [AW-1:0]    src_base,
   input  logic [AW-1:0]    dst_base,
   output logic             mem_req,
   output logic [AW-1:0]    mem_addr,
   input  logic             mem_ack,
   input  logic [23:0]      mem_rdata,
   output logic [2:0][23:0] cache,
   output logic [1:0]       kernelsel,
   output logic [1:0]       funtype,
   output logic [1:0]       funcode,
   input  logic [bus-1:0]   alu_result,
   output logic             wr_req,
   output logic [AW-1:0]    wr_addr,
   output logic [bus-1:0]   wr_data,
   input  logic             wr_ack,
   output logic             busy,
   output logic             done,
   output logic [DW-1:0]    win_count,
   output logic [2:0]       state_dbg
);

   localparam logic [DW-1:0] DW_THREE = DW'(3);

   kws_state_t    state;
   logic [1:0]    ksel_q;
   logic [DW-1:0] w_q;
   logic [DW-1:0] h_q;
   logic [AW-1:0] src_q;
   logic [AW-1:0] dst_q;

   logic          clear;
   logic          row_adv;
   logic          win_adv;
   logic          fetch_ack;
   logic          write_ack;
   logic [1:0]    row;
   logic          last_row;
   logic          last_win;
   logic [AW-1:0] src_addr;
   logic [AW-1:0] dst_addr;

   assign fetch_ack = (state == FETCH) && mem_req && mem_ack;
   assign write_ack = (state == WRITE) && wr_req && wr_ack;
   assign clear     = (state == IDLE) && start;
   assign row_adv   = fetch_ack && !last_row;
   assign win_adv   = write_ack;

   assign mem_addr  = src_addr;
   assign wr_addr   = dst_addr;
   assign kernelsel = ksel_q;
   assign funcode   = FUNTYPE_ARITH;
   assign state_dbg = state;

   window_addr_gen #(
      .AW (AW),
      .DW (DW)
   ) u_addr_gen (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .row_adv  (row_adv),
      .win_adv  (win_adv),
      .img_w    (w_q),
      .img_h    (h_q),
      .src_base (src_q),
      .dst_base (dst_q),
      .src_addr (src_addr),
      .dst_addr (dst_addr),
      .row      (row),
      .last_row (last_row),
      .last_win (last_win)
   );

   // Job FSM with registered handshake, ALU control and status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         ksel_q    <= '0;
         w_q       <= '0;
         h_q       <= '0;
         src_q     <= '0;
         dst_q     <= '0;
         cache     <= '0;
         mem_req   <= 1'b0;
         wr_req    <= 1'b0;
         wr_data   <= '0;
         funtype   <= FUNTYPE_ARITH;
         busy      <= 1'b0;
         done      <= 1'b0;
         win_count <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  ksel_q    <= ksel_in;
                  w_q       <= img_w;
                  h_q       <= img_h;
                  src_q     <= src_base;
                  dst_q     <= dst_base;
                  win_count <= '0;
                  // An image smaller than the kernel has no windows at all.
                  if (img_w < DW_THREE || img_h < DW_THREE) begin
                     state <= DONE;
                  end else begin
                     state   <= FETCH;
                     mem_req <= 1'b1;
                     busy    <= 1'b1;
                  end
               end
            end
            FETCH: begin
               if (fetch_ack) begin
                  case (row)
                     2'd0:    cache[0] <= mem_rdata;
                     2'd1:    cache[1] <= mem_rdata;
                     default: cache[2] <= mem_rdata;
                  endcase
                  if (last_row) begin
                     mem_req <= 1'b0;
                     funtype <= FUNTYPE_KERNEL;
                     state   <= EXEC;
                  end
               end
            end
            EXEC: begin
               wr_data <= alu_result;
               funtype <= FUNTYPE_ARITH;
               wr_req  <= 1'b1;
               state   <= WRITE;
            end
            WRITE: begin
               if (write_ack) begin
                  wr_req    <= 1'b0;
                  win_count <= win_count + DW'(1);
                  if (last_win) begin
                     busy  <= 1'b0;
                     state <= DONE;
                  end else begin
                     mem_req <= 1'b1;
                     state   <= FETCH;
                  end
               end
            end
            DONE: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_kernel_window_sequencer.sv
// Bench for kernel_window_sequencer: memory/write responders with
// configurable wait states, an ALU stub, and a reference model that lists
// every window's reads, cache contents and result write in raster order.
module tb_kernel_window_sequencer;

   localparam int BUS = 4;
   localparam int AW  = 16;
   localparam int DW  = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic             start;
   logic [1:0]       ksel_in;
   logic [DW-1:0]    img_w;
   logic [DW-1:0]    img_h;
   logic [AW-1:0]    src_base;
   logic [AW-1:0]    dst_base;
   logic             mem_req;
   logic [AW-1:0]    mem_addr;
   logic             mem_ack;
   logic [23:0]      mem_rdata;
   logic [2:0][23:0] cache;
   logic [1:0]       kernelsel;
   logic [1:0]       funtype;
   logic [1:0]       funcode;
   logic [BUS-1:0]   alu_result;
   logic             wr_req;
   logic [AW-1:0]    wr_addr;
   logic [BUS-1:0]   wr_data;
   logic             wr_ack;
   logic             busy;
   logic             done;
   logic [DW-1:0]    win_count;
   logic [2:0]       state_dbg;

   kernel_window_sequencer #(.bus(BUS), .AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .ksel_in    (ksel_in),
      .img_w      (img_w),
      .img_h      (img_h),
      .src_base   (src_base),
      .dst_base   (dst_base),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .cache      (cache),
      .kernelsel  (kernelsel),
      .funtype    (funtype),
      .funcode    (funcode),
      .alu_result (alu_result),
      .wr_req     (wr_req),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_ack     (wr_ack),
      .busy       (busy),
      .done       (done),
      .win_count  (win_count),
      .state_dbg  (state_dbg)
   );

   // ---------------- memory image and ALU stub ----------------
   logic [7:0] mem [0:65535];

   function automatic logic [23:0] rd(input logic [15:0] a);
      logic [15:0] a1;
      logic [15:0] a2;
      a1 = a + 16'd1;
      a2 = a + 16'd2;
      return {mem[a], mem[a1], mem[a2]};
   endfunction

   function automatic logic [3:0] alu_stub(input logic [23:0] r0, input logic [23:0] r1,
                                           input logic [23:0] r2, input logic [1:0] ks);
      logic [3:0] t;
      t = r0[23:20] + r1[11:8] + r2[3:0];
      return t ^ {2'b00, ks} ^ r0[3:0] ^ r2[19:16];
   endfunction

   assign alu_result = alu_stub(cache[0], cache[1], cache[2], kernelsel);

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;

   logic [15:0] exp_rd_q[$];
   logic [31:0] exp_wr_q[$];
   logic [73:0] exp_cache_q[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- responders ----------------
   int mem_wait = 0;
   int wr_wait  = 0;
   bit stray_en = 1'b0;

   initial begin
      int cnt;
      cnt = 0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            if (cnt >= mem_wait) begin
               mem_ack = 1'b1;
               mem_rdata = rd(mem_addr);
               cnt = 0;
            end else begin
               mem_ack = 1'b0;
               mem_rdata = '0;
               cnt++;
            end
         end else begin
            cnt = 0;
            mem_ack = stray_en && ($urandom_range(0, 3) == 0);
            mem_rdata = 24'($urandom);
         end
      end
   end

   initial begin
      int cnt;
      cnt = 0;
      wr_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (wr_req) begin
            if (cnt >= wr_wait) begin
               wr_ack = 1'b1;
               cnt = 0;
            end else begin
               wr_ack = 1'b0;
               cnt++;
            end
         end else begin
            cnt = 0;
            wr_ack = stray_en && ($urandom_range(0, 2) == 0);
         end
      end
   end

   // ---------------- monitor ----------------
   int done_count  = 0;
   int done_cyc    = 0;
   int start_cyc   = 0;
   int ft_cycles   = 0;
   int req_cycles  = 0;

   initial begin
      logic        p_mreq, p_mack, p_wreq, p_wack;
      logic [15:0] p_maddr, p_waddr;
      logic [3:0]  p_wdata;
      p_mreq = 0; p_mack = 0; p_wreq = 0; p_wack = 0;
      p_maddr = 0; p_waddr = 0; p_wdata = 0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            p_mreq = 0;
            p_wreq = 0;
         end else begin
            if (mem_req || wr_req) req_cycles++;
            if (mem_req && p_mreq && !p_mack) chk("mem_addr_stable", mem_addr, p_maddr);
            if (wr_req && p_wreq && !p_wack) begin
               chk("wr_addr_stable", wr_addr, p_waddr);
               chk("wr_data_stable", wr_data, p_wdata);
            end
            if (mem_req && mem_ack) begin
               if (exp_rd_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL rd_extra: got read 0x%0h expected no read", mem_addr);
               end else chk("rd_addr", mem_addr, exp_rd_q.pop_front());
            end
            if (wr_req && wr_ack) begin
               if (exp_wr_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL wr_extra: got write 0x%0h expected no write", wr_addr);
               end else chk("wr_addr_data", {wr_addr, 12'd0, wr_data}, exp_wr_q.pop_front());
            end
            if (funtype == 2'b11) begin
               ft_cycles++;
               if (exp_cache_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL exec_extra: got exec cycle expected none");
               end else chk("exec_cache_ksel", {kernelsel, cache}, exp_cache_q.pop_front());
            end else begin
               chk("funtype_off", funtype, 2'b00);
            end
            if (mem_req || wr_req || funtype == 2'b11) chk("busy_active", busy, 1'b1);
            if (done) begin
               done_count++;
               done_cyc = cyc;
               chk("busy_at_done", busy, 1'b0);
            end
            p_mreq = mem_req; p_mack = mem_ack; p_maddr = mem_addr;
            p_wreq = wr_req;  p_wack = wr_ack;  p_waddr = wr_addr; p_wdata = wr_data;
         end
      end
   end

   // ---------------- reference model + driver tasks ----------------
   function automatic int nwin(input int w, input int h);
      return (w >= 3 && h >= 3) ? (w - 2) * (h - 2) : 0;
   endfunction

   task automatic flush_q();
      exp_rd_q.delete();
      exp_wr_q.delete();
      exp_cache_q.delete();
   endtask

   task automatic launch(input int w, input int h, input logic [15:0] src, input logic [15:0] dst,
                         input logic [1:0] ks, input int mw, input int ww);
      for (int y = 0; y <= h - 3; y++) begin
         for (int x = 0; x <= w - 3; x++) begin
            logic [23:0] rows [3];
            logic [15:0] a;
            for (int r = 0; r < 3; r++) begin
               a = src + 16'((y + r) * w + x);
               exp_rd_q.push_back(a);
               rows[r] = rd(a);
            end
            exp_cache_q.push_back({ks, rows[2], rows[1], rows[0]});
            exp_wr_q.push_back({dst + 16'(y * (w - 2) + x), 12'd0,
                                alu_stub(rows[0], rows[1], rows[2], ks)});
         end
      end
      mem_wait = mw;
      wr_wait = ww;
      done_count = 0;
      ft_cycles = 0;
      req_cycles = 0;
      img_w = 16'(w);
      img_h = 16'(h);
      src_base = src;
      dst_base = dst;
      ksel_in = ks;
      start = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      #2;
      // Scramble the job inputs: the DUT must work from its latched copies.
      start = 1'b0;
      img_w = 16'($urandom);
      img_h = 16'($urandom);
      src_base = 16'($urandom);
      dst_base = 16'($urandom);
      ksel_in = 2'($urandom);
   endtask

   task automatic finish_job(input int nw, input bit degen, input bit disturb);
      bit seen;
      int budget;
      seen = 1'b0;
      budget = nw * 120 + 40;
      for (int i = 0; i < budget; i++) begin
         if (disturb && i == 6) begin
            start = 1'b1;
            ksel_in = 2'($urandom);
            img_w = 16'($urandom_range(3, 9));
            img_h = 16'($urandom_range(3, 9));
            src_base = 16'($urandom);
            dst_base = 16'($urandom);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         #2;
         if (done_count != 0) begin
            seen = 1'b1;
            break;
         end
      end
      start = 1'b0;
      chk("done_seen", seen, 1'b1);
      if (!seen) begin
         rst = 1'b0;
         @(negedge clk);
         #2;
         rst = 1'b1;
      end else begin
         repeat (3) @(negedge clk);
         #2;
         chk("done_once", done_count, 1);
         chk("win_count", win_count, nw);
         chk("busy_idle", busy, 1'b0);
         chk("exec_cycles", ft_cycles, nw);
         chk("rd_left", exp_rd_q.size(), 0);
         chk("wr_left", exp_wr_q.size(), 0);
         chk("exec_left", exp_cache_q.size(), 0);
         if (degen) begin
            chk("degen_no_req", req_cycles, 0);
            chk("degen_done_latency", done_cyc - start_cyc, 2);
         end
      end
      flush_q();
   endtask

   task automatic run_job(input int w, input int h, input logic [15:0] src, input logic [15:0] dst,
                          input logic [1:0] ks, input int mw, input int ww, input bit disturb);
      launch(w, h, src, dst, ks, mw, ww);
      finish_job(nwin(w, h), (w < 3 || h < 3), disturb);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit found;
      logic [71:0] rowbytes;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      start = 1'b0;
      ksel_in = '0;
      img_w = '0;
      img_h = '0;
      src_base = '0;
      dst_base = '0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_wr_req", wr_req, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_funtype", funtype, 2'b00);
      chk("rst_funcode", funcode, 2'b00);
      chk("rst_kernelsel", kernelsel, 2'b00);
      chk("rst_win_count", win_count, 0);
      chk("rst_cache", cache, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_state", state_dbg, 0);
      rst = 1'b1;
      @(negedge clk);
      #2;

      // Two windows on a 4x3 image, zero-wait handshakes
      run_job(4, 3, 16'h0100, 16'h0200, 2'b01, 0, 0, 1'b0);

      // Known row contents for a single 3x3 window
      rowbytes = 72'hAABBCC_112233_445566;
      for (int i = 0; i < 9; i++) mem[16'h0300 + 16'(i)] = rowbytes[71 - 8 * i -: 8];
      run_job(3, 3, 16'h0300, 16'h0340, 2'b10, 0, 0, 1'b0);

      // Slow memory and slow writes
      run_job(5, 4, 16'h1000, 16'h2000, 2'b11, 5, 3, 1'b0);

      // Images smaller than the kernel
      run_job(2, 5, 16'h0100, 16'h0200, 2'b00, 0, 0, 1'b0);
      run_job(7, 2, 16'h0100, 16'h0200, 2'b01, 0, 0, 1'b0);

      // Address wrap-around at the top of the address space
      run_job(6, 4, 16'hFFF8, 16'hFFFE, 2'b01, 1, 0, 1'b0);

      // Reset in the middle of window 1's fetch
      launch(4, 4, 16'h0500, 16'h0600, 2'b01, 2, 1);
      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         #2;
         if (win_count == 1 && mem_req) begin
            found = 1'b1;
            break;
         end
      end
      chk("reach_window1_fetch", found, 1'b1);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("abort_state", state_dbg, 0);
      chk("abort_mem_req", mem_req, 1'b0);
      chk("abort_wr_req", wr_req, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_cache", cache, 0);
      flush_q();
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b1;
      repeat (4) @(negedge clk);
      #2;
      chk("abort_no_done", done_count, 0);
      chk("abort_idle_req", mem_req, 1'b0);
      run_job(4, 4, 16'h0500, 16'h0600, 2'b01, 2, 1, 1'b0);

      // Start re-pulsed mid-job with stray acks around
      stray_en = 1'b1;
      run_job(5, 4, 16'h0400, 16'h0800, 2'b11, 1, 2, 1'b1);

      // Randomized jobs
      for (int j = 0; j < 8; j++) begin
         run_job($urandom_range(1, 7), $urandom_range(1, 6), 16'($urandom), 16'($urandom),
                 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
